// File: rtl/lif_layer_scheduler_pkg.sv
// Shared widths, FSM state encoding, config bundle and the leak/saturate helper
// for the time-multiplexed LIF layer.
package lif_pkg;
  localparam int V_W       = 5;
  localparam int W_W       = 2;
  localparam int IN_SPIKES = 8;
  localparam int REF_W     = 5;
  localparam int DECAY_W   = 3;
  localparam int WWORD_W   = W_W * IN_SPIKES;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_UPDATE, S_DONE} lif_state_e;

  // Step configuration captured on an accepted start.
  typedef struct packed {
    logic [V_W-1:0]     thr;
    logic [DECAY_W-1:0] decay;
    logic [REF_W-1:0]   rper;
  } lif_cfg_t;

  // Saturating add of potential and current with the leak applied before
  // saturation: (a+b) is kept at full width, the decay is floored at 0, and
  // only then is the result clamped to the potential range.
  function automatic logic [V_W-1:0] sat_add_leak(input logic [V_W-1:0] a,
                                                  input logic [V_W-1:0] b,
                                                  input logic [DECAY_W-1:0] d);
    logic [V_W:0] s;
    logic [V_W:0] dx;
    s  = {1'b0, a} + {1'b0, b};
    dx = {{(V_W+1-DECAY_W){1'b0}}, d};
    s  = (s >= dx) ? (s - dx) : '0;
    return s[V_W] ? {V_W{1'b1}} : s[V_W-1:0];
  endfunction
endpackage

// File: rtl/lif_layer_scheduler_if.sv
// Weight memory read port: the scheduler is master, the weight RAM is slave.
// Read data is valid exactly one cycle after a read strobe.
interface lif_layer_scheduler_if #(parameter int IDX_W = 3);
  import lif_pkg::*;
  logic               wmem_rd_en;
  logic [IDX_W-1:0]   wmem_addr;
  logic [WWORD_W-1:0] wmem_rdata;

  modport master (output wmem_rd_en, output wmem_addr, input wmem_rdata);
  modport slave  (input wmem_rd_en, input wmem_addr, output wmem_rdata);
endinterface

// File: rtl/lif_layer_scheduler_update.sv
// Combinational LIF datapath for one neuron: weighted input current, leak,
// saturation, threshold compare and refractory handling.
module lif_update_unit
  import lif_pkg::*;
(
  input  logic [IN_SPIKES-1:0] spikes_i,
  input  logic [WWORD_W-1:0]   wword_i,
  input  logic [V_W-1:0]       v_i,
  input  logic [REF_W-1:0]     ref_i,
  input  lif_cfg_t             cfg_i,
  output logic [V_W-1:0]       v_next_o,
  output logic [REF_W-1:0]     ref_next_o,
  output logic                 fire_o
);
  logic [V_W-1:0] cur;
  logic [V_W-1:0] s;

  // Input current: sum of 2-bit weights of the active presynaptic inputs (max 24).
  always_comb begin
    cur = '0;
    for (int k = 0; k < IN_SPIKES; k++)
      if (spikes_i[k]) cur = cur + V_W'(wword_i[W_W*k +: W_W]);
  end

  assign s = sat_add_leak(v_i, cur, cfg_i.decay);

  // Refractory neurons drain their counter and drop the current; others fire on s >= thr.
  always_comb begin
    v_next_o   = s;
    ref_next_o = '0;
    fire_o     = 1'b0;
    if (ref_i != '0) begin
      v_next_o   = '0;
      ref_next_o = ref_i - REF_W'(1);
    end else if (s >= cfg_i.thr) begin
      fire_o     = 1'b1;
      v_next_o   = '0;
      ref_next_o = cfg_i.rper;
    end
  end
endmodule

// File: rtl/lif_layer_scheduler.sv
// Time-multiplexed LIF layer: one shared update unit walks NUM_NEURONS virtual
// neurons per step, fetching each weight word then writing back v/ref.
module lif_layer_scheduler
  import lif_pkg::*;
#(
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    start,
  input  logic [IN_SPIKES-1:0]    input_spikes,
  input  logic [V_W-1:0]          threshold,
  input  logic [DECAY_W-1:0]      decay,
  input  logic [REF_W-1:0]        refractory_period,
  lif_layer_scheduler_if.master   wmem,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_NEURONS-1:0]  spikes_out,
  output logic [V_W-1:0]          dbg_potential
);
  lif_state_e             state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [IN_SPIKES-1:0]   spk_q;
  lif_cfg_t               cfg_q;
  logic [V_W-1:0]         v_q   [NUM_NEURONS];
  logic [REF_W-1:0]       ref_q [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] shadow_q, shadow_d;
  logic                   busy_q, done_q, rd_en_q;
  logic [IDX_W-1:0]       addr_q;
  logic [NUM_NEURONS-1:0] out_q;
  logic [V_W-1:0]         dbg_q;

  logic [V_W-1:0]   v_nx;
  logic [REF_W-1:0] ref_nx;
  logic             fire;
  logic             last;

  lif_update_unit u_upd (
    .spikes_i   (spk_q),
    .wword_i    (wmem.wmem_rdata),
    .v_i        (v_q[idx_q]),
    .ref_i      (ref_q[idx_q]),
    .cfg_i      (cfg_q),
    .v_next_o   (v_nx),
    .ref_next_o (ref_nx),
    .fire_o     (fire)
  );

  assign last = (idx_q == IDX_W'(NUM_NEURONS-1));

  // Shadow spike vector with the current neuron's result merged in, so the
  // final update can publish the full vector in the same edge as done.
  always_comb begin
    shadow_d        = shadow_q;
    shadow_d[idx_q] = fire;
  end

  // Step sequencer: IDLE -> (FETCH -> UPDATE)*N -> DONE -> IDLE; enable=0 freezes all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      spk_q    <= '0;
      cfg_q    <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      out_q    <= '0;
      dbg_q    <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_q[i]   <= '0;
        ref_q[i] <= '0;
      end
    end else if (enable) begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          spk_q   <= input_spikes;
          cfg_q   <= '{thr: threshold, decay: decay, rper: refractory_period};
          idx_q   <= '0;
          addr_q  <= '0;
          rd_en_q <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          rd_en_q <= 1'b0;
          state_q <= S_UPDATE;
        end
        S_UPDATE: begin
          v_q[idx_q]   <= v_nx;
          ref_q[idx_q] <= ref_nx;
          shadow_q     <= shadow_d;
          dbg_q        <= v_nx;
          if (last) begin
            out_q   <= shadow_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            addr_q  <= idx_q + IDX_W'(1);
            rd_en_q <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wmem.wmem_rd_en = rd_en_q;
  assign wmem.wmem_addr  = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign spikes_out      = out_q;
  assign dbg_potential   = dbg_q;
endmodule

// File: tb/tb_lif_layer_scheduler.sv
// Directed bench for lif_layer_scheduler: a table of back-to-back time steps
// with hand-computed spike vectors and potentials, plus hand-written freeze,
// start-while-busy and reset sequences.
module tb_lif_layer_scheduler;
  localparam int N     = 8;
  localparam int IDX_W = 3;
  localparam int T_DONE = 2*N + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       start = 1'b0;
  logic [7:0] input_spikes = '0;
  logic [4:0] threshold = '0;
  logic [2:0] decay = '0;
  logic [4:0] refractory_period = '0;
  logic       busy, done;
  logic [N-1:0] spikes_out;
  logic [4:0] dbg_potential;

  logic [15:0] mem [N];
  int n_chk = 0;
  int n_fail = 0;

  lif_layer_scheduler_if #(.IDX_W(IDX_W)) wif ();

  lif_layer_scheduler #(.NUM_NEURONS(N)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .input_spikes(input_spikes), .threshold(threshold), .decay(decay),
    .refractory_period(refractory_period), .wmem(wif),
    .busy(busy), .done(done), .spikes_out(spikes_out), .dbg_potential(dbg_potential)
  );

  always #5 clk = ~clk;

  // Weight RAM model: registered read, data valid the cycle after the strobe.
  always @(posedge clk) if (wif.wmem_rd_en) wif.wmem_rdata <= mem[wif.wmem_addr];

  typedef struct {
    logic [7:0]  spk;
    logic [15:0] w;
    logic [7:0]  wmask;
    logic [4:0]  thr;
    logic [2:0]  dec;
    logic [4:0]  rp;
    logic [7:0]  exp_out;
    logic [4:0]  exp_dbg;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, " busy"}, int'(busy), 0);
    chk({nm, " done"}, int'(done), 0);
    chk({nm, " rd_en"}, int'(wif.wmem_rd_en), 0);
    chk({nm, " addr"}, int'(wif.wmem_addr), 0);
    chk({nm, " spikes_out"}, int'(spikes_out), 0);
    chk({nm, " dbg"}, int'(dbg_potential), 0);
  endtask

  // One time step; freeze_at/pulse_at < 0 disable the corresponding disturbance.
  task automatic run_step(input vec_t v, input int freeze_at, input int pulse_at,
                          input int exp_done, input string nm);
    int got, nf;
    logic prev_rd;
    for (int i = 0; i < N; i++) mem[i] = v.wmask[i] ? v.w : 16'h0;
    @(negedge clk);
    input_spikes = v.spk; threshold = v.thr; decay = v.dec;
    refractory_period = v.rp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = -1; nf = 0; prev_rd = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (freeze_at >= 0 && c > freeze_at && c <= freeze_at + 3)
        chk({nm, " rd_en held"}, int'(wif.wmem_rd_en), 1);
      if (wif.wmem_rd_en && !prev_rd) begin
        chk({nm, " addr"}, int'(wif.wmem_addr), nf);
        nf++;
      end
      prev_rd = wif.wmem_rd_en;
      if (done) begin got = c; break; end
      start  = (c == pulse_at);
      enable = !(freeze_at >= 0 && c >= freeze_at && c < freeze_at + 3);
      @(negedge clk);
    end
    enable = 1'b1; start = 1'b0;
    chk({nm, " done cycle"}, got, exp_done);
    chk({nm, " fetches"}, nf, N);
    chk({nm, " spikes_out"}, int'(spikes_out), int'(v.exp_out));
    chk({nm, " dbg"}, int'(dbg_potential), int'(v.exp_dbg));
    chk({nm, " busy in done"}, int'(busy), 1);
    @(negedge clk);
    chk({nm, " busy after"}, int'(busy), 0);
    chk({nm, " done pulse"}, int'(done), 0);
  endtask

  task automatic watch_no_done(input string nm);
    int cnt = 0;
    for (int c = 0; c < 2*N + 4; c++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk({nm, " stray done"}, cnt, 0);
    chk({nm, " idle busy"}, int'(busy), 0);
  endtask

  initial begin
    vec_t hv;
    //             spk    w        mask   thr dec rp  out    dbg
    tbl[0]  = '{8'hFF, 16'h0000, 8'hFF, 10, 0, 0, 8'h00, 0};
    tbl[1]  = '{8'hFF, 16'h5555, 8'hFF, 10, 0, 0, 8'h00, 8};
    tbl[2]  = '{8'hFF, 16'h5555, 8'hFF, 10, 0, 0, 8'hFF, 0};
    tbl[3]  = '{8'hFF, 16'h0000, 8'hFF, 10, 7, 0, 8'h00, 0};
    tbl[4]  = '{8'hFF, 16'hFFFF, 8'hFF, 31, 0, 0, 8'h00, 24};
    tbl[5]  = '{8'hFF, 16'hFFFF, 8'hFF, 31, 0, 0, 8'hFF, 0};
    tbl[6]  = '{8'hFF, 16'h5555, 8'hFF, 10, 0, 2, 8'h00, 8};
    tbl[7]  = '{8'hFF, 16'h5555, 8'hFF, 10, 0, 2, 8'hFF, 0};
    tbl[8]  = '{8'hFF, 16'h5555, 8'hFF, 10, 0, 2, 8'h00, 0};
    tbl[9]  = '{8'hFF, 16'h5555, 8'hFF, 10, 0, 2, 8'h00, 0};
    tbl[10] = '{8'hFF, 16'h5555, 8'hFF, 10, 0, 2, 8'h00, 8};
    tbl[11] = '{8'hFF, 16'h5555, 8'hFF, 10, 0, 2, 8'hFF, 0};
    tbl[12] = '{8'hFF, 16'h0000, 8'hFF,  0, 0, 0, 8'h00, 0};
    tbl[13] = '{8'hFF, 16'h0000, 8'hFF,  0, 0, 0, 8'h00, 0};
    tbl[14] = '{8'hFF, 16'h0000, 8'hFF,  0, 0, 0, 8'hFF, 0};
    tbl[15] = '{8'hFF, 16'h5555, 8'h0F,  8, 0, 0, 8'h0F, 0};
    tbl[16] = '{8'hFF, 16'h5555, 8'hF0,  9, 0, 0, 8'h00, 8};
    tbl[17] = '{8'hFF, 16'h5555, 8'hF0,  9, 0, 0, 8'hF0, 0};
    tbl[18] = '{8'h0F, 16'hFFFF, 8'hFF, 31, 5, 0, 8'h00, 7};
    for (int i = 0; i < N; i++) mem[i] = '0;

    // Reset held with random stimulus: everything stays at its reset value.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'($urandom); enable = 1'($urandom);
      input_spikes = 8'($urandom); threshold = 5'($urandom);
      decay = 3'($urandom); refractory_period = 5'($urandom);
      #1 chk_reset_outs("hold reset");
    end
    @(negedge clk);
    start = 1'b0; enable = 1'b1; reset = 1'b1;

    for (int i = 0; i < 19; i++) run_step(tbl[i], -1, -1, T_DONE, $sformatf("vec%0d", i));

    // Freeze during FETCH of neuron 3 (cycle 7): same result, done 3 cycles later.
    hv = '{8'hFF, 16'h5555, 8'hFF, 10, 0, 0, 8'hFF, 0};
    run_step(hv, 7, -1, T_DONE + 3, "freeze");

    // start pulsed mid-step is dropped: one done only.
    hv = '{8'hFF, 16'h5555, 8'hFF, 8, 0, 0, 8'hFF, 0};
    run_step(hv, -1, 5, T_DONE, "busy start");
    watch_no_done("busy start");

    // Reset at cycle 5 of a step: immediate abort, outputs and neuron state clear.
    for (int i = 0; i < N; i++) mem[i] = 16'h5555;
    @(negedge clk);
    input_spikes = 8'hFF; threshold = 5'd20; decay = '0; refractory_period = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 5; c++) @(negedge clk);
    reset = 1'b0;
    #1 chk_reset_outs("mid reset");
    @(negedge clk);
    reset = 1'b1;
    watch_no_done("mid reset");

    hv = '{8'hFF, 16'h5555, 8'hFF, 20, 0, 0, 8'h00, 8};
    run_step(hv, -1, -1, T_DONE, "post reset A");
    hv = '{8'hFF, 16'h5555, 8'hFF, 20, 0, 0, 8'h00, 16};
    run_step(hv, -1, -1, T_DONE, "post reset B");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
